ir_rc_sensor_reader: RTL
========================

IR_RC_SENSOR_READER -- requirements
Module: ir_rc_sensor_reader

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with clock port clk and reset port rst_n.
REQ-002 The block SHALL take these parameters:
  - N_CH, default 5, number of IR reflectance channels.
  - CHARGE_CYCLES, default 1000, capacitor charge time (10 us at 100 MHz).
  - TIMEOUT_CYCLES, default 250000, maximum discharge window.
  - COUNT_W, default 18, count width; SHALL satisfy 2^COUNT_W > TIMEOUT_CYCLES.
REQ-003 The block SHALL have these ports, clock and reset first:
  - clk, in, 1, system clock.
  - rst_n, in, 1, async active-low reset.
  - start, in, 1, one-cycle request to begin a measurement.
  - sense_in, in, N_CH, pad readback from the per-channel tristate GPIO io lines.
  - dir, out, N_CH, per-channel GPIO drive enable (1 = drive).
  - write, out, N_CH, per-channel GPIO drive value.
  - busy, out, 1, high while a measurement is in progress.
  - done, out, 1, one-cycle pulse when results are valid.
  - count, out, N_CH*COUNT_W, per-channel discharge times; channel k occupies bits [k*COUNT_W +: COUNT_W].
  - timeout, out, N_CH, per-channel flag: no discharge seen within the window.

Function
REQ-004 Each sense_in bit SHALL pass through a 2-flop synchronizer before use; all timing below refers to the synchronized value.
REQ-005 The FSM SHALL have states IDLE, CHARGE, MEASURE and DONE.
REQ-006 IDLE: dir=0 and write=0; a start seen high SHALL move to CHARGE on the next edge.
REQ-007 CHARGE: dir=all ones and write=all ones for exactly CHARGE_CYCLES cycles, then the FSM SHALL enter MEASURE.
REQ-008 On entry to MEASURE, dir=0 and write=0, the shared cycle counter SHALL load 0, and all per-channel captured bits SHALL clear.
REQ-009 MEASURE: the counter SHALL increment by 1 per cycle.
REQ-010 In MEASURE, the first cycle a channel's synchronized input is 0 and that channel is not yet captured, the block SHALL latch the counter value into that channel's count and set its captured bit.
REQ-011 Later transitions on a captured channel SHALL be ignored.
REQ-012 Simultaneous captures on several channels in one cycle SHALL all latch the same counter value.
REQ-013 MEASURE SHALL exit to DONE when all channels are captured, or when the counter equals TIMEOUT_CYCLES-1, whichever comes first.
REQ-014 On timeout, every uncaptured channel SHALL get count=TIMEOUT_CYCLES and timeout=1.
REQ-015 On timeout, captured channels SHALL keep their value and get timeout=0.
REQ-016 A capture in the same cycle as the timeout SHALL take priority, recording the counter value with timeout=0.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 count and timeout SHALL hold their values until the next MEASURE entry.
REQ-019 busy SHALL be 1 in CHARGE, MEASURE and DONE, and 0 in IDLE.
REQ-020 start SHALL be ignored in every state other than IDLE.
REQ-021 The counter SHALL never wrap; it saturates at TIMEOUT_CYCLES-1.
REQ-022 Reported count includes the 2-cycle synchronizer latency; no compensation SHALL be applied.

Reset
REQ-023 While rst_n=0, the block SHALL hold: state=IDLE, dir=0, write=0, busy=0, done=0, count=0, timeout=0, counters=0 and synchronizer flops=0.
REQ-024 Reset asserted mid-CHARGE or mid-MEASURE SHALL immediately release the pads (dir=0) and abort the measurement with no done pulse.
REQ-025 After rst_n deasserts, the first measurement SHALL require a fresh start.

Structure
REQ-026 Package ir_pkg SHALL hold the FSM state enum and the default constants CHARGE_CYCLES, TIMEOUT_CYCLES and COUNT_W.
REQ-027 The synchronizer SHALL be a sub-module ir_sync2, parameterized by width and instantiated once with width N_CH.
REQ-028 The dir/write outputs SHALL connect bit-per-channel to the existing GPIO tristate blocks, with sense_in taken from their io pads.

Verification (sim parameters N_CH=5, CHARGE_CYCLES=10, TIMEOUT_CYCLES=100, COUNT_W=8)
REQ-029 Basic measurement: start pulse, then model channels falling 20/35/50/65/80 cycles after MEASURE entry.
  - Required: dir=1F for 10 cycles.
  - Required: counts 22/37/52/67/82, timeout=00000.
  - Required: done pulse one cycle after the last capture.
REQ-030 Timeout: channel 3 never falls, others fall at 30.
  - Required: count[3]=100, timeout=01000.
  - Required: done pulse after MEASURE cycle 99.
  - Required: others=32.
REQ-031 Simultaneous capture: all channels fall on the same cycle 40.
  - Required: all counts=42.
  - Required: exit to DONE on the next cycle.
  - Required: a channel re-rising and falling again later does not change its count.
REQ-032 start asserted during CHARGE, MEASURE and DONE is ignored; exactly one done pulse per accepted start.
REQ-033 rst_n pulsed low at MEASURE cycle 15:
  - Required: dir=0 and busy=0 immediately, all outputs 0, no done pulse.
  - Required: the next start measures normally.
REQ-034 Edge timing: a channel falls exactly at the counter value TIMEOUT_CYCLES-3, so it is captured at 99.
  - Required: count=99, timeout=0, per the capture-over-timeout priority.

Source files
------------

// File: rtl/ir_rc_sensor_reader_pkg.sv
// ir_pkg: shared types and default constants for the IR RC reflectance
// sensor reader.
//   ir_state_t            - measurement FSM states
//   DEF_CHARGE_CYCLES     - default capacitor charge time in clk cycles
//   DEF_TIMEOUT_CYCLES    - default maximum discharge window in clk cycles
//   DEF_COUNT_W           - default per-channel count width
package ir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHARGE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } ir_state_t;

    localparam int DEF_CHARGE_CYCLES  = 1000;
    localparam int DEF_TIMEOUT_CYCLES = 250000;
    localparam int DEF_COUNT_W        = 18;

endpackage

// File: rtl/ir_rc_sensor_reader_sync2.sv
// ir_sync2: two-flop synchronizer for a bus of independent asynchronous
// bits (each bit is synchronized on its own; no bus coherency implied).
//   clk      - destination clock
//   rst_n    - async active-low reset, clears both flop stages
//   i_async  - asynchronous input bits
//   o_sync   - synchronized bits, two clk cycles behind i_async
module ir_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/ir_rc_sensor_reader.sv
// ir_rc_sensor_reader: RC-discharge reader for N_CH IR reflectance sensors.
// A start pulse charges every sensor capacitor by driving the GPIO pads high
// for CHARGE_CYCLES, then releases the pads and times how long each line
// takes to read low. Channels that never fall inside TIMEOUT_CYCLES report
// count = TIMEOUT_CYCLES with their timeout flag set.
//   clk, rst_n  - clock, async active-low reset
//   start       - one-cycle request, honoured only in IDLE
//   sense_in    - pad readback from the tristate GPIO io lines
//   dir, write  - per-channel pad drive enable / drive value
//   busy        - high from CHARGE through DONE
//   done        - one-cycle pulse when count/timeout are valid
//   count       - channel k at [k*COUNT_W +: COUNT_W], discharge time in
//                 cycles including the 2-cycle synchronizer latency
//   timeout     - per-channel "no discharge seen" flag
module ir_rc_sensor_reader
    import ir_pkg::*;
#(
    parameter int N_CH           = 5,
    parameter int CHARGE_CYCLES  = DEF_CHARGE_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int COUNT_W        = DEF_COUNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [N_CH-1:0]         sense_in,
    output logic [N_CH-1:0]         dir,
    output logic [N_CH-1:0]         write,
    output logic                    busy,
    output logic                    done,
    output logic [N_CH*COUNT_W-1:0] count,
    output logic [N_CH-1:0]         timeout
);

    localparam int                 CHG_W    = $clog2(CHARGE_CYCLES + 1);
    localparam logic [CHG_W-1:0]   CHG_LAST = CHG_W'(CHARGE_CYCLES - 1);
    localparam logic [COUNT_W-1:0] TMO_LAST = COUNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [COUNT_W-1:0] TMO_VAL  = COUNT_W'(TIMEOUT_CYCLES);

    ir_state_t r_state;
    ir_state_t w_state_nxt;

    logic [CHG_W-1:0]        r_chg_cnt;
    logic [COUNT_W-1:0]      r_cnt;
    logic [N_CH-1:0]         r_captured;
    logic [N_CH*COUNT_W-1:0] r_count;
    logic [N_CH-1:0]         r_timeout;

    logic [N_CH-1:0] w_sense;
    logic [N_CH-1:0] w_cap_now;
    logic            w_all_cap;
    logic            w_tmo;
    logic            w_meas_entry;

    ir_sync2 #(
        .WIDTH (N_CH)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (sense_in),
        .o_sync  (w_sense)
    );

    // A channel captures on the first low sample after MEASURE entry.
    assign w_cap_now    = (r_state == ST_MEASURE) ? (~w_sense & ~r_captured) : '0;
    // Include this cycle's captures so DONE follows the last capture directly.
    assign w_all_cap    = &(r_captured | w_cap_now);
    assign w_tmo        = (r_cnt == TMO_LAST);
    assign w_meas_entry = (r_state == ST_CHARGE) && (w_state_nxt == ST_MEASURE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        dir         = '0;
        write       = '0;
        busy        = 1'b1;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_nxt = ST_CHARGE;
                end
            end
            ST_CHARGE: begin
                dir   = '1;
                write = '1;
                if (r_chg_cnt == CHG_LAST) begin
                    w_state_nxt = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (w_all_cap || w_tmo) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chg_cnt  <= '0;
            r_cnt      <= '0;
            r_captured <= '0;
            r_count    <= '0;
            r_timeout  <= '0;
        end else begin
            if (r_state == ST_CHARGE) begin
                r_chg_cnt <= r_chg_cnt + 1'b1;
            end else begin
                r_chg_cnt <= '0;
            end

            if (w_meas_entry) begin
                r_cnt      <= '0;
                r_captured <= '0;
                r_count    <= '0;
                r_timeout  <= '0;
            end else if (r_state == ST_MEASURE) begin
                // Saturate rather than wrap at the last window cycle.
                if (!w_tmo) begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_captured <= r_captured | w_cap_now;
                for (int k = 0; k < N_CH; k++) begin
                    // A capture in the timeout cycle wins over the timeout.
                    if (w_cap_now[k]) begin
                        r_count[k*COUNT_W +: COUNT_W] <= r_cnt;
                    end else if (w_tmo && !r_captured[k]) begin
                        r_count[k*COUNT_W +: COUNT_W] <= TMO_VAL;
                        r_timeout[k]                  <= 1'b1;
                    end
                end
            end
        end
    end

    assign count   = r_count;
    assign timeout = r_timeout;

endmodule
